regfile_seq_ctrl: RTL and testbench
===================================

REGFILE_SEQ_CTRL -- requirements
Module: regfile_seq_ctrl

Interface
REQ-001 Parameter Address_Width, default 5, SHALL set register-address width (32 registers).
REQ-002 Parameter Data_Width, default 32, SHALL set register/ALU data width.
REQ-003 Parameter Ctrl_Width, default 3, SHALL set ALU control-code width.
REQ-004 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst  in  1  SHALL be the reset, asynchronous and active-high.
REQ-006 instr_valid  in  1  SHALL flag a pending operation request.
REQ-007 instr_ready  out  1  SHALL flag that the controller accepts a request this cycle.
REQ-008 instr_rs1, instr_rs2, instr_rd  in  Address_Width each  SHALL carry request source/destination addresses.
REQ-009 instr_aluctrl  in  Ctrl_Width  SHALL carry the request ALU operation code.
REQ-010 rs1, rs2, rd  out  Address_Width each  SHALL drive the register-file read/write addresses.
REQ-011 en  out  1  SHALL drive the register-file write enable.
REQ-012 din  out  Data_Width  SHALL drive the register-file write data.
REQ-013 alu_ctrl  out  Ctrl_Width  SHALL drive the ALU operation code.
REQ-014 alu_result  in  Data_Width  SHALL carry the combinational ALU output (operands from regfile rd1/rd2).
REQ-015 busy  out  1; done  out  1; op_count  out  16  SHALL report activity, completion pulse, completed-operation count.

Function
REQ-016 FSM states SHALL be IDLE, READ, EXEC, WRITE; transitions IDLE->READ on handshake, READ->EXEC, EXEC->WRITE, WRITE->IDLE, each unconditional after one cycle except IDLE.
REQ-017 Handshake SHALL occur on a rising edge where instr_valid=1 and instr_ready=1; instr_ready SHALL be 1 only in IDLE with rst=0.
REQ-018 On handshake, instr_rs1/rs2/rd/aluctrl SHALL be latched; request fields SHALL be sampled at no other time.
REQ-019 instr_valid while not in IDLE SHALL be ignored; no request buffering.
REQ-020 rs1, rs2, rd, alu_ctrl SHALL present the latched values in all states, including IDLE after completion (no change until next handshake).
REQ-021 READ SHALL present rs1/rs2 so the registered regfile read returns rd1/rd2 during EXEC.
REQ-022 At the EXEC->WRITE edge, alu_result SHALL be captured into an internal result register; din SHALL equal that register.
REQ-023 en SHALL be 1 only in WRITE and only if latched rd != 0; writes to register 0 SHALL be suppressed but still count as completed.
REQ-024 done SHALL be 1 for exactly the WRITE cycle; op_count SHALL increment at the WRITE->IDLE edge, wrapping 0xFFFF->0x0000.
REQ-025 busy SHALL equal (state != IDLE).
REQ-026 Latency: handshake at edge k -> register write at edge k+3; next handshake earliest at edge k+4 (throughput 1 op / 4 cycles).
REQ-027 Back-to-back dependent ops (op2.rs == op1.rd) SHALL read op1's written value, guaranteed by REQ-026 spacing; no forwarding path.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, en=0, done=0, busy=0, instr_ready=0, and clear rs1, rs2, rd, alu_ctrl, din, result register, op_count to 0.
REQ-029 rst asserted mid-operation (any of READ/EXEC/WRITE) SHALL abort the operation with no register write; instr_ready SHALL become 1 on the first cycle with rst=0.

Verification
REQ-030 Single op: regfile x1=5, x2=7; request rs1=1, rs2=2, rd=3, aluctrl=ADD at edge 0 -> en=1, rd=3, din=12 in cycle after edge 2; x3=12 after edge 3; done one cycle; op_count=1.
REQ-031 Dependent pair: op1 x3=x1+x2 (12), op2 x4=x3+x1 issued at earliest ready -> x4=17; instr_ready low for 3 cycles between handshakes.
REQ-032 rd=0: request rd=0, any operands -> en stays 0 throughout, done pulses, op_count increments, x0 unchanged.
REQ-033 Busy ignore: hold instr_valid=1 with changing fields during READ/EXEC/WRITE -> no field change on rs1/rs2/rd/alu_ctrl, one op completed only.
REQ-034 Reset mid-op: assert rst during EXEC -> en never asserts, destination register unchanged, all outputs 0, op_count=0; new request after release completes normally.
REQ-035 Counter wrap: preload op_count to 0xFFFF via 65535 ops (or forced state) -> next completion yields 0x0000.

Source files
------------

// File: rtl/regfile_seq_ctrl.sv
// rtl/regfile_seq_ctrl.sv - four-phase sequencer driving a register file and ALU
module regfile_seq_ctrl #(
  parameter int Address_Width = 5,
  parameter int Data_Width    = 32,
  parameter int Ctrl_Width    = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [Address_Width-1:0] instr_rs1,
  input  logic [Address_Width-1:0] instr_rs2,
  input  logic [Address_Width-1:0] instr_rd,
  input  logic [Ctrl_Width-1:0]    instr_aluctrl,
  output logic [Address_Width-1:0] rs1,
  output logic [Address_Width-1:0] rs2,
  output logic [Address_Width-1:0] rd,
  output logic                     en,
  output logic [Data_Width-1:0]    din,
  output logic [Ctrl_Width-1:0]    alu_ctrl,
  input  logic [Data_Width-1:0]    alu_result,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t                state;
  logic [Data_Width-1:0] result;

  // Ready must drop the instant reset is asserted and rise on the first cycle after release.
  assign instr_ready = (state == IDLE) && !rst;

  // Write data always comes straight from the captured ALU result.
  assign din = result;

  // Sequencer: latch request, wait for registered read, capture ALU, write back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rs1      <= '0;
      rs2      <= '0;
      rd       <= '0;
      alu_ctrl <= '0;
      result   <= '0;
      en       <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      op_count <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          // Fields are sampled only here; requests seen in other states are dropped.
          if (instr_valid) begin
            rs1      <= instr_rs1;
            rs2      <= instr_rs2;
            rd       <= instr_rd;
            alu_ctrl <= instr_aluctrl;
            busy     <= 1'b1;
            state    <= READ;
          end
        end
        READ: begin
          // Register file samples rs1/rs2 on this edge; rd1/rd2 are valid in EXEC.
          state <= EXEC;
        end
        EXEC: begin
          result <= alu_result;
          done   <= 1'b1;
          en     <= (rd != '0);
          state  <= WRITE;
        end
        WRITE: begin
          // A suppressed write to x0 still counts as a completed operation.
          done     <= 1'b0;
          en       <= 1'b0;
          busy     <= 1'b0;
          op_count <= op_count + 16'd1;
          state    <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          en    <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// tb/tb_regfile_seq_ctrl.sv - bench for regfile_seq_ctrl with register file, ALU and reference model
module tb_regfile_seq_ctrl;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_valid;
  logic          instr_ready;
  logic [AW-1:0] instr_rs1, instr_rs2, instr_rd;
  logic [CW-1:0] instr_aluctrl;
  logic [AW-1:0] rs1, rs2, rd;
  logic          en;
  logic [DW-1:0] din;
  logic [CW-1:0] alu_ctrl;
  logic [DW-1:0] alu_result;
  logic          busy, done;
  logic [15:0]   op_count;

  logic [DW-1:0] regs[32];
  logic [DW-1:0] init_regs[32];
  logic [DW-1:0] ref_regs[32];
  logic          load;
  logic [DW-1:0] rd1, rd2;
  logic [15:0]   ref_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_seq_ctrl #(.Address_Width(AW), .Data_Width(DW), .Ctrl_Width(CW)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_rd(instr_rd),
    .instr_aluctrl(instr_aluctrl),
    .rs1(rs1), .rs2(rs2), .rd(rd), .en(en), .din(din), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .busy(busy), .done(done), .op_count(op_count)
  );

  // ALU opcode meanings used by this environment.
  function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [CW-1:0] c);
    case (c)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << b[4:0];
      3'd6:    return a >> b[4:0];
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // Register file with registered read ports and synchronous write.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 32; i++) regs[i] <= init_regs[i];
    end else if (en) begin
      regs[rd] <= din;
    end
    rd1 <= regs[rs1];
    rd2 <= regs[rs2];
  end

  // Combinational ALU fed by the register-file read data.
  always_comb alu_result = alu_f(rd1, rd2, alu_ctrl);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic junk_fields();
    instr_rs1     = AW'($urandom);
    instr_rs2     = AW'($urandom);
    instr_rd      = AW'($urandom);
    instr_aluctrl = CW'($urandom);
  endtask

  // One complete operation, checked cycle by cycle from IDLE back to IDLE.
  task automatic run_op(input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic [AW-1:0] d, input logic [CW-1:0] c, input bit junk);
    logic [DW-1:0] exp;
    int w;
    w = 0;
    while (instr_ready !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_op", instr_ready, 1);
    instr_valid   = 1'b1;
    instr_rs1     = a;
    instr_rs2     = b;
    instr_rd      = d;
    instr_aluctrl = c;
    exp = alu_f(ref_regs[a], ref_regs[b], c);

    @(negedge clk);
    if (junk) junk_fields(); else instr_valid = 1'b0;
    chk("read_busy", busy, 1);
    chk("read_ready", instr_ready, 0);
    chk("read_done", done, 0);
    chk("read_en", en, 0);
    chk("read_rs1", rs1, a);
    chk("read_rs2", rs2, b);
    chk("read_rd", rd, d);
    chk("read_aluctrl", alu_ctrl, c);

    @(negedge clk);
    if (junk) junk_fields();
    chk("exec_busy", busy, 1);
    chk("exec_ready", instr_ready, 0);
    chk("exec_en", en, 0);
    chk("exec_done", done, 0);
    chk("exec_rs1", rs1, a);

    @(negedge clk);
    if (junk) junk_fields();
    chk("write_en", en, (d != 0));
    chk("write_done", done, 1);
    chk("write_din", din, exp);
    chk("write_rd", rd, d);
    chk("write_ready", instr_ready, 0);

    @(negedge clk);
    instr_valid = 1'b0;
    if (d != 0) ref_regs[d] = exp;
    ref_count = ref_count + 16'd1;
    chk("idle_done", done, 0);
    chk("idle_en", en, 0);
    chk("idle_busy", busy, 0);
    chk("idle_ready", instr_ready, 1);
    chk("op_count", op_count, ref_count);
    chk("reg_written", regs[d], ref_regs[d]);
    chk("idle_rs1", rs1, a);
    chk("idle_rd", rd, d);
    chk("idle_aluctrl", alu_ctrl, c);
  endtask

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    instr_rs1 = '0;
    instr_rs2 = '0;
    instr_rd = '0;
    instr_aluctrl = '0;
    load = 1'b1;
    for (int i = 0; i < 32; i++) init_regs[i] = $urandom;
    init_regs[0] = 32'd0;
    init_regs[1] = 32'd5;
    init_regs[2] = 32'd7;
    for (int i = 0; i < 32; i++) ref_regs[i] = init_regs[i];
    ref_count = 16'd0;

    repeat (2) @(negedge clk);
    chk("rst_ready", instr_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_en", en, 0);
    chk("rst_din", din, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_rs1", rs1, 0);
    chk("rst_rd", rd, 0);
    chk("rst_aluctrl", alu_ctrl, 0);
    load = 1'b0;
    rst = 1'b0;
    #1;
    chk("ready_after_rst", instr_ready, 1);

    // Single ADD, then a dependent op issued at the earliest ready.
    run_op(5'd1, 5'd2, 5'd3, 3'd0, 1'b0);
    chk("x3_is_12", regs[3], 32'd12);
    run_op(5'd3, 5'd1, 5'd4, 3'd0, 1'b0);
    chk("x4_is_17", regs[4], 32'd17);

    // Write to x0 is suppressed but completes.
    run_op(5'd5, 5'd6, 5'd0, 3'd0, 1'b0);
    chk("x0_unchanged", regs[0], 32'd0);

    // Valid held high with changing fields while busy.
    run_op(5'd1, 5'd2, 5'd7, 3'd1, 1'b1);
    chk("busy_ignore_count", op_count, 16'd4);

    // Reset during EXEC aborts without a write.
    @(negedge clk);
    instr_valid = 1'b1;
    instr_rs1 = 5'd1;
    instr_rs2 = 5'd2;
    instr_rd = 5'd9;
    instr_aluctrl = 3'd0;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_en", en, 0);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", instr_ready, 0);
    chk("abort_rd", rd, 0);
    chk("abort_din", din, 0);
    chk("abort_op_count", op_count, 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_en_hold", en, 0);
    end
    rst = 1'b0;
    #1;
    chk("abort_ready_release", instr_ready, 1);
    chk("abort_x9_unchanged", regs[9], ref_regs[9]);
    ref_count = 16'd0;
    run_op(5'd9, 5'd1, 5'd9, 3'd0, 1'b0);

    // Randomized operations against the reference model.
    for (int n = 0; n < 24; n++) begin
      run_op(AW'($urandom), AW'($urandom), AW'($urandom), CW'($urandom), bit'($urandom_range(0, 1)));
    end

    // Counter wrap from a preloaded value.
    @(negedge clk);
    force dut.op_count = 16'hFFFE;
    #1;
    release dut.op_count;
    ref_count = 16'hFFFE;
    chk("preload_count", op_count, 16'hFFFE);
    run_op(AW'($urandom), AW'($urandom), AW'($urandom), CW'($urandom), 1'b0);
    run_op(AW'($urandom), AW'($urandom), AW'($urandom), CW'($urandom), 1'b0);
    chk("count_wrapped", op_count, 16'h0000);

    for (int i = 0; i < 32; i++) chk("final_regfile", regs[i], ref_regs[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
